sr_flag_arbiter: RTL and testbench

- Shares a bank of NFLAG set/reset flag flip-flops between NREQ requesters.
- Each requester posts one {s,r} command against one flag index. A round-robin arbiter grants one command per cycle and applies it to the flag bank.
- The illegal {s,r}=11 command never reaches a flag: it is rejected with an error.
- Sits between the SR flag storage and its client blocks.

---
 rtl/sr_flag_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/sr_flag_arbiter.sv | 94 +++++++++
 tb/tb_sr_flag_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_pkg.sv
// rtl/sr_flag_pkg.sv - SR command encodings and default bank sizes
package sr_flag_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int NFLAG_DEF = 8;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_RST  = 2'b01,
    OP_SET  = 2'b10,
    OP_ILL  = 2'b11
  } sr_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first eligible index at or above rr_ptr, wrapping
module rr_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] winner,
  output logic [PW-1:0]   winner_idx,
  output logic            valid
);

  int j;

  // Scan from the farthest offset down so the nearest eligible index overwrites the rest.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    j          = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (eligible[j]) begin
        winner     = '0;
        winner[j]  = 1'b1;
        winner_idx = PW'(j);
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - shares a bank of SR flags between requesters, one command applied per cycle
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NFLAG = NFLAG_DEF,
  parameter int IDXW  = (NFLAG > 1) ? $clog2(NFLAG) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      err,
  output logic [NFLAG-1:0]     flags,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic [NFLAG-1:0] flags_q, flags_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  winner;
  logic [PW-1:0]    win_idx;
  logic             win_valid;
  sr_op_e           sel_op;
  logic [IDXW-1:0]  sel_idx;
  logic             idx_ok;

  // The requester holding gnt this cycle has already been served; it must wait one cycle.
  assign eligible = req & ~gnt_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .eligible   (eligible),
    .rr_ptr     (rr_ptr_q),
    .winner     (winner),
    .winner_idx (win_idx),
    .valid      (win_valid)
  );

  always_comb begin
    sel_op   = sr_op_e'(op[2*win_idx +: 2]);
    sel_idx  = idx[IDXW*win_idx +: IDXW];
    idx_ok   = (32'(sel_idx) < 32'(NFLAG));
    gnt_d    = winner;
    busy_d   = win_valid;
    err_d    = '0;
    flags_d  = flags_q;
    rr_ptr_d = rr_ptr_q;
    if (win_valid) begin
      rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
      if (!idx_ok || sel_op == OP_ILL) begin
        err_d[win_idx] = 1'b1;
      end else begin
        case (sel_op)
          OP_SET:  flags_d[sel_idx] = 1'b1;
          OP_RST:  flags_d[sel_idx] = 1'b0;
          default: flags_d = flags_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q    <= '0;
      err_q    <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt   = gnt_q;
  assign err   = err_q;
  assign flags = flags_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - scoreboard bench for sr_flag_arbiter, 8-flag and 6-flag instances share stimulus
module tb_sr_flag_arbiter;

  localparam int NREQ = 4;
  localparam int IDXW = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [IDXW*NREQ-1:0] idx;
  logic [NREQ-1:0]      gnt_a, err_a, gnt_b, err_b;
  logic [7:0]           flags_a;
  logic [5:0]           flags_b;
  logic                 busy_a, busy_b;

  always #5 clk = ~clk;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(8)) dut_a (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .gnt(gnt_a), .err(err_a), .flags(flags_a), .busy(busy_a)
  );

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(6)) dut_b (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .gnt(gnt_b), .err(err_b), .flags(flags_b), .busy(busy_b)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] err_a;
    logic [7:0] flags_a;
    logic [3:0] err_b;
    logic [5:0] flags_b;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a requester list scanned from a pointer, plus bit-vector flag banks.
  int       m_ptr = 0;
  int       m_win, m_o, m_x;
  bit [3:0] m_last = '0;
  bit [7:0] m_fa = '0;
  bit [7:0] m_fb = '0;
  bit       m_ea, m_eb;
  exp_t     m_e;

  function automatic void apply_cmd(input int nflag, input int o, input int x,
                                    inout bit [7:0] f, output bit e);
    e = 1'b0;
    if (o == 3 || x >= nflag) e = 1'b1;
    else if (o == 2) f[x] = 1'b1;
    else if (o == 1) f[x] = 1'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr  = 0;
      m_last = '0;
      m_fa   = '0;
      m_fb   = '0;
      sb_q.delete();
    end else begin
      m_win = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (m_win < 0 && req[(m_ptr + k) % NREQ] && !m_last[(m_ptr + k) % NREQ])
          m_win = (m_ptr + k) % NREQ;
      end
      m_e.gnt   = '0;
      m_e.err_a = '0;
      m_e.err_b = '0;
      if (m_win >= 0) begin
        m_o = int'(op[2*m_win +: 2]);
        m_x = int'(idx[IDXW*m_win +: IDXW]);
        apply_cmd(8, m_o, m_x, m_fa, m_ea);
        apply_cmd(6, m_o, m_x, m_fb, m_eb);
        m_e.gnt[m_win]   = 1'b1;
        m_e.err_a[m_win] = m_ea;
        m_e.err_b[m_win] = m_eb;
        m_ptr = (m_win + 1) % NREQ;
      end
      m_last      = m_e.gnt;
      m_e.flags_a = m_fa;
      m_e.flags_b = m_fb[5:0];
      sb_q.push_back(m_e);
    end
  end

  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got gnt %0h expected a queued response at %0t", gnt_a, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_gnt_a",   gnt_a,   mon_e.gnt);
        chk("sb_gnt_b",   gnt_b,   mon_e.gnt);
        chk("sb_busy_a",  busy_a,  |mon_e.gnt);
        chk("sb_busy_b",  busy_b,  |mon_e.gnt);
        chk("sb_err_a",   err_a,   mon_e.err_a);
        chk("sb_flags_a", flags_a, mon_e.flags_a);
        chk("sb_err_b",   err_b,   mon_e.err_b);
        chk("sb_flags_b", flags_b, mon_e.flags_b);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input bit r, input int o, input int x);
    req[i]             = r;
    op[2*i +: 2]       = 2'(o);
    idx[IDXW*i +: IDXW] = IDXW'(x);
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] g;

  initial begin
    req = 4'b1111;
    op  = '0;
    idx = '0;
    repeat (3) cyc();
    chk("rst_gnt", gnt_a, 4'b0000);
    chk("rst_flags", flags_a, 8'h00);
    chk("rst_busy", busy_a, 1'b0);

    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("rr_seq", gnt_a, rr_exp[c]);
    end
    req = '0;
    cyc();

    set_cmd(0, 1, 2, 3);
    cyc();
    chk("single_set_gnt", gnt_a, 4'b0001);
    chk("single_set_flags", flags_a, 8'h08);
    chk("single_set_err", err_a, 4'b0000);
    set_cmd(0, 1, 1, 3);
    cyc();
    chk("regrant_gap", gnt_a, 4'b0000);
    cyc();
    chk("single_rst_gnt", gnt_a, 4'b0001);
    chk("single_rst_flags", flags_a, 8'h00);

    set_cmd(0, 0, 0, 0);
    set_cmd(2, 1, 2, 5);
    cyc();
    chk("pre_ill_flags", flags_a, 8'h20);
    set_cmd(2, 1, 3, 5);
    cyc();
    cyc();
    chk("ill_gnt", gnt_a, 4'b0100);
    chk("ill_err", err_a, 4'b0100);
    chk("ill_flags", flags_a, 8'h20);
    set_cmd(2, 0, 0, 0);

    set_cmd(0, 1, 2, 7);
    cyc();
    chk("oor_err_b", err_b, 4'b0001);
    chk("oor_flags_b", flags_b, 6'h20);
    chk("oor_err_a", err_a, 4'b0000);
    chk("oor_flags_a", flags_a, 8'hA0);
    set_cmd(0, 0, 0, 0);

    set_cmd(1, 1, 2, 0);
    set_cmd(2, 1, 1, 0);
    cyc();
    chk("order1_gnt", gnt_a, 4'b0010);
    chk("order1_flags", flags_a, 8'hA1);
    set_cmd(1, 0, 0, 0);
    cyc();
    chk("order2_gnt", gnt_a, 4'b0100);
    chk("order2_flags", flags_a, 8'hA0);
    set_cmd(2, 0, 0, 0);

    set_cmd(3, 1, 2, 1);
    cyc();
    chk("pre_midrst_gnt", gnt_a, 4'b1000);
    rst = 1'b0;
    #1;
    chk("midrst_gnt", gnt_a, 4'b0000);
    chk("midrst_flags", flags_a, 8'h00);
    chk("midrst_busy", busy_a, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("rearb_gnt", gnt_a, 4'b1000);
    chk("rearb_flags", flags_a, 8'h02);
    set_cmd(3, 0, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      cyc();
      g = gnt_a;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i])
          set_cmd(i, ($urandom % 4) != 0, $urandom % 4, $urandom % 8);
        else if (!req[i])
          set_cmd(i, ($urandom % 3) == 0, $urandom % 4, $urandom % 8);
        else if (($urandom % 4) == 0)
          set_cmd(i, 1, $urandom % 4, $urandom % 8);
      end
      if (c % 700 == 350) begin
        rst = 1'b0;
        cyc();
        rst = 1'b1;
      end
    end
    req = '0;
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
